// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritised level stalls, a timed hold, deferred branch flush,
// saturating stall statistics and a sticky stall watchdog.
module pipe_ctrl #(
  parameter int                          STAGES      = 6,
  parameter int                          NREQ        = 3,
  parameter logic [NREQ*STAGES-1:0]      MASK        = {6'b000010, 6'b000111, 6'b011111},
  parameter int                          CW          = 4,
  parameter logic [STAGES-1:0]           TIMED_MASK  = 6'b001111,
  parameter logic [STAGES-1:0]           FLUSH_MASK  = 6'b000110,
  parameter int                          FLUSH_STAGE = 3,
  parameter int                          TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stall_req,
  input  logic              timed_req,
  input  logic [CW-1:0]     timed_len,
  input  logic              flush_req,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              busy,
  output logic [31:0]       stall_cnt,
  output logic              stall_timeout
);

  localparam int             RW     = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0]  RUN_TO = RW'(TIMEOUT);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_pending;
  logic [RW-1:0]     r_run, w_run_nxt;
  logic [31:0]       r_stall_cnt;
  logic              r_timeout;
  logic [STAGES-1:0] w_req_mask, w_raw;
  logic              w_hold, w_issue, w_any_stall;

  // Descending scan so the lowest-index active source overwrites the others.
  always_comb begin
    w_req_mask = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (stall_req[i]) w_req_mask = MASK[i*STAGES +: STAGES];
    end
  end

  assign w_hold  = (r_state == HOLD);
  assign w_raw   = w_req_mask | (w_hold ? TIMED_MASK : '0);
  assign w_issue = (flush_req | r_pending) & ~w_raw[FLUSH_STAGE];

  always_comb begin
    stall = w_raw;
    flush = '0;
    if (rst) begin
      stall = '0;
    end else if (w_issue) begin
      stall = w_raw & ~FLUSH_MASK;
      flush = FLUSH_MASK;
    end
  end

  assign w_any_stall = |stall;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (timed_req && (timed_len != '0)) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = timed_len;
        end
      end
      HOLD: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt <= CW'(1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Run length saturates at the watchdog threshold; only the crossing matters.
  always_comb begin
    w_run_nxt = '0;
    if (w_any_stall) w_run_nxt = (r_run == RUN_TO) ? r_run : r_run + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_run       <= '0;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= (flush_req | r_pending) & w_raw[FLUSH_STAGE];
      r_run     <= w_run_nxt;
      if (w_any_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_run_nxt == RUN_TO) r_timeout <= 1'b1;
    end
  end

  assign busy          = w_hold | r_pending;
  assign stall_cnt     = r_stall_cnt;
  assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic against a
// cycle-level reference model built from remaining-hold-cycles and a pending flag.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  stall_req;
  logic        timed_req;
  logic [3:0]  timed_len;
  logic        flush_req;
  logic [5:0]  stall, flush;
  logic        busy, stall_timeout;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] SRC_MASK [3] = '{6'b011111, 6'b000111, 6'b000010};
  localparam logic [5:0] T_MASK = 6'b001111;
  localparam logic [5:0] F_MASK = 6'b000110;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .timed_req(timed_req),
    .timed_len(timed_len), .flush_req(flush_req), .stall(stall), .flush(flush),
    .busy(busy), .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_hold;
  bit          m_pend;
  longint      m_cnt;
  int          m_run;
  bit          m_to;
  logic [5:0]  e_raw, e_stall, e_flush;
  bit          e_issue, e_busy;

  function automatic logic [5:0] ref_mask(input logic [2:0] r);
    for (int i = 0; i < 3; i++) if (r[i]) return SRC_MASK[i];
    return 6'b0;
  endfunction

  task automatic model_eval();
    e_raw   = ref_mask(stall_req) | ((m_hold > 0) ? T_MASK : 6'b0);
    e_issue = (flush_req || m_pend) && !e_raw[3];
    e_stall = rst ? 6'b0 : (e_issue ? (e_raw & ~F_MASK) : e_raw);
    e_flush = (rst || !e_issue) ? 6'b0 : F_MASK;
    e_busy  = (m_hold > 0) || m_pend;
  endtask

  task automatic model_advance();
    if (rst) begin
      m_hold = 0; m_pend = 0; m_cnt = 0; m_run = 0; m_to = 0;
    end else begin
      if (e_stall != 6'b0) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        m_run++;
        if (m_run >= 1023) m_to = 1;
      end else begin
        m_run = 0;
      end
      m_pend = (flush_req || m_pend) && e_raw[3];
      if (m_hold > 0) m_hold--;
      else if (timed_req && timed_len != 0) m_hold = timed_len;
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] sr, input logic tr,
                       input logic [3:0] tl, input logic fr);
    rst = r; stall_req = sr; timed_req = tr; timed_len = tl; flush_req = fr;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 3'b111, 1, 4'd5, 1);
    for (int c = 0; c < 2; c++) begin
      sample();
      checks++; if (stall !== 6'b0) begin errors++; $display("FAIL reset_stall: got %b want 000000", stall); end
      checks++; if (flush !== 6'b0) begin errors++; $display("FAIL reset_flush: got %b want 000000", flush); end
      advance();
    end
    drive(0, 3'b000, 0, 4'd0, 0);
    sample();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    checks++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", stall_timeout); end
    advance();
  endtask

  task automatic test_priority();
    logic [2:0] reqs [4];
    logic [5:0] exps [4];
    reqs = '{3'b011, 3'b110, 3'b100, 3'b000};
    exps = '{6'b011111, 6'b000111, 6'b000010, 6'b000000};
    for (int k = 0; k < 4; k++) begin
      drive(0, reqs[k], 0, 4'd0, 0);
      sample();
      checks++; if (stall !== exps[k]) begin errors++; $display("FAIL priority_%0d: got %b want %b", k, stall, exps[k]); end
      advance();
    end
    sample();
    checks++; if (stall_cnt !== 32'(m_cnt)) begin errors++; $display("FAIL priority_cnt: got %0d want %0d", stall_cnt, m_cnt); end
    advance();
  endtask

  task automatic test_timed_hold();
    logic [5:0] exp_s [6];
    exp_s = '{6'b0, T_MASK, T_MASK, T_MASK, 6'b0, 6'b0};
    for (int k = 0; k < 6; k++) begin
      if (k == 0)      drive(0, 3'b000, 1, 4'd3, 0);
      else if (k == 2) drive(0, 3'b000, 1, 4'd7, 0);
      else             drive(0, 3'b000, 0, 4'd0, 0);
      sample();
      checks++; if (stall !== exp_s[k]) begin errors++; $display("FAIL timed_stall_t%0d: got %b want %b", k, stall, exp_s[k]); end
      checks++; if (busy !== (exp_s[k] != 6'b0)) begin errors++; $display("FAIL timed_busy_t%0d: got %b want %b", k, busy, exp_s[k] != 6'b0); end
      advance();
    end
    drive(0, 3'b000, 1, 4'd0, 0);
    sample(); advance();
    drive(0, 3'b000, 0, 4'd0, 0);
    sample();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timed_len0_busy: got %b want 0", busy); end
    advance();
  endtask

  task automatic test_flush_defer();
    drive(0, 3'b000, 0, 4'd0, 1);
    sample();
    checks++; if (flush !== F_MASK) begin errors++; $display("FAIL flush_direct: got %b want %b", flush, F_MASK); end
    advance();
    for (int k = 0; k < 7; k++) begin
      drive(0, (k <= 4) ? 3'b001 : 3'b000, 0, 4'd0, (k == 0 || k == 2));
      sample();
      if (k <= 4) begin
        checks++; if (flush !== 6'b0) begin errors++; $display("FAIL defer_flush_t%0d: got %b want 000000", k, flush); end
        if (k >= 1) begin
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL defer_busy_t%0d: got %b want 1", k, busy); end
        end
      end else if (k == 5) begin
        checks++; if (flush !== F_MASK) begin errors++; $display("FAIL defer_issue: got %b want %b", flush, F_MASK); end
      end else begin
        checks++; if (flush !== 6'b0 || busy !== 1'b0) begin errors++; $display("FAIL defer_clear: got flush %b busy %b want 000000 0", flush, busy); end
      end
      advance();
    end
  endtask

  task automatic test_flush_during_hold();
    for (int k = 0; k < 8; k++) begin
      drive(0, (k == 6) ? 3'b010 : 3'b000, (k == 0), (k == 0) ? 4'd5 : 4'd0, (k == 2));
      sample();
      if (k >= 1 && k <= 5) begin
        checks++; if (flush !== 6'b0) begin errors++; $display("FAIL hold_flush_t%0d: got %b want 000000", k, flush); end
      end else if (k == 6) begin
        checks++; if (flush !== F_MASK) begin errors++; $display("FAIL hold_flush_issue: got %b want %b", flush, F_MASK); end
        checks++; if (stall !== 6'b000001) begin errors++; $display("FAIL hold_flush_stall: got %b want 000001", stall); end
      end else if (k == 7) begin
        checks++; if (flush !== 6'b0) begin errors++; $display("FAIL hold_flush_once: got %b want 000000", flush); end
      end
      advance();
    end
  endtask

  task automatic test_timeout();
    drive(1, 3'b000, 0, 4'd0, 0);
    sample(); advance();
    drive(0, 3'b100, 0, 4'd0, 0);
    for (int k = 0; k < 1024; k++) begin
      sample();
      if (k == 1022) begin
        checks++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", stall_timeout); end
      end
      if (k == 1023) begin
        checks++; if (stall_timeout !== 1'b1) begin errors++; $display("FAIL timeout_fire: got %b want 1", stall_timeout); end
      end
      advance();
    end
    drive(0, 3'b000, 0, 4'd0, 0);
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++; if (stall_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", stall_timeout); end
      checks++; if (stall_cnt !== 32'd1024) begin errors++; $display("FAIL timeout_cnt: got %0d want 1024", stall_cnt); end
      advance();
    end
    drive(1, 3'b000, 0, 4'd0, 0);
    sample(); advance();
    drive(0, 3'b000, 0, 4'd0, 0);
    sample();
    checks++; if (stall_timeout !== 1'b0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL timeout_rst: got %b/%0d want 0/0", stall_timeout, stall_cnt); end
    advance();
  endtask

  task automatic test_reset_mid_hold();
    drive(0, 3'b000, 1, 4'd8, 0);
    sample(); advance();
    drive(0, 3'b001, 0, 4'd0, 1);
    sample(); advance();
    drive(0, 3'b001, 0, 4'd0, 0);
    sample();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    advance();
    drive(1, 3'b000, 0, 4'd0, 0);
    sample(); advance();
    drive(0, 3'b000, 0, 4'd0, 0);
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++; if (stall !== 6'b0 || flush !== 6'b0 || busy !== 1'b0 || stall_cnt !== 32'd0) begin
        errors++; $display("FAIL mid_reset_t%0d: got stall %b flush %b busy %b cnt %0d want all 0", k, stall, flush, busy, stall_cnt);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(1) == 0) ? 3'($urandom) : 3'b000,
            ($urandom_range(5) == 0), 4'($urandom), ($urandom_range(4) == 0));
      sample();
      checks++; if (stall !== e_stall) begin errors++; $display("FAIL rand_stall c%0d: got %b want %b", c, stall, e_stall); end
      checks++; if (flush !== e_flush) begin errors++; $display("FAIL rand_flush c%0d: got %b want %b", c, flush, e_flush); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, e_busy); end
      checks++; if (stall_cnt !== 32'(m_cnt)) begin errors++; $display("FAIL rand_cnt c%0d: got %0d want %0d", c, stall_cnt, m_cnt); end
      checks++; if (stall_timeout !== m_to) begin errors++; $display("FAIL rand_timeout c%0d: got %b want %b", c, stall_timeout, m_to); end
      advance();
    end
  endtask

  initial begin
    m_hold = 0; m_pend = 0; m_cnt = 0; m_run = 0; m_to = 0;
    drive(1, 3'b000, 0, 4'd0, 0);
    test_reset();
    test_priority();
    test_timed_hold();
    test_flush_defer();
    test_flush_during_hold();
    test_timeout();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
